// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit.
//
// Sequences the shared-memory multicycle datapath one state per cycle. The
// instruction in flight is identified by op/funct3; memory accesses stall on
// mem_ready. Unsupported opcodes and branch funct3 values park the controller
// in a trap state until reset.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   op, funct3        opcode and branch condition select from the IR
//   Zero, ALUR31      ALU zero flag and sign bit of the ALU result
//   mem_ready         memory completes the current access this cycle
//   mem_req           memory access requested
//   AdrSrc .. RegWrite    single-bit datapath enables/selects
//   ResultSrc .. ImmSrc   two-bit datapath selects
//   illegal_instr     sticky trap flag
//   state             current state encoding (debug)
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       illegal_instr,
  output logic [3:0] state
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrLink = 4'd12,
    StUpper    = 4'd13,
    StTrap     = 4'd14
  } state_e;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   take_branch;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // funct3 010/011 never reach here; they trap in decode.
  always_comb begin
    take_branch = 1'b0;
    unique case (funct3)
      3'b000:          take_branch = Zero;
      3'b001:          take_branch = ~Zero;
      3'b100, 3'b110:  take_branch = ALUR31;
      3'b101, 3'b111:  take_branch = ~ALUR31;
      default:         take_branch = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready) state_d = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = (funct3[2:1] == 2'b01) ? StTrap : StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui, OpAuipc:  state_d = StUpper;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr:   state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      StJalr:     state_d = StJalrLink;
      StJalrLink: state_d = StAluWb;
      StUpper:    state_d = StFetch;
      StTrap:     state_d = StTrap;
      default:    state_d = StTrap;
    endcase
  end

  // Flag rises together with the entry into the trap state.
  always_comb begin
    illegal_d = illegal_q | (state_d == StTrap);
  end

  // Output logic
  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      StDecode: begin
        // Precompute branch/jal target into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb: RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = take_branch;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      StJalr: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      StJalrLink: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      StUpper: begin
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpStore:  ImmSrc = 2'b01;
      OpBranch: ImmSrc = 2'b10;
      OpJal:    ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  assign illegal_instr = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes the expected
// state/controls for each cycle it drives; a monitor on the falling edge pops
// and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, ALUR31, mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic       illegal_instr;
  logic [3:0] state;

  multicycle_controller dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .Zero         (Zero),
    .ALUR31       (ALUR31),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .AdrSrc       (AdrSrc),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .ImmSrc       (ImmSrc),
    .illegal_instr(illegal_instr),
    .state        (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic [1:0]  imm;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] cur_imm;

  // {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
  //  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_instr}
  logic [14:0] obs;
  assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_instr};

  // Control table per state; en is the data-dependent enable where one exists.
  function automatic logic [14:0] ctrl_of(input logic [3:0] st, input logic en);
    case (st)
      4'd0:    return {1'b1, 1'b0, en,   en,   1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0};
      4'd1:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0};
      4'd2:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0};
      4'd3:    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd4:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd5:    return {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd6:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0};
      4'd7:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0};
      4'd8:    return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd9:    return {1'b0, 1'b0, 1'b0, en,   1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0};
      4'd10:   return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
      4'd11:   return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, 1'b0};
      4'd12:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0};
      4'd13:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0};
      4'd14:   return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
      default: return '0;
    endcase
  endfunction

  // Push the expectation for the cycle just driven, then advance one cycle.
  task automatic cyc(input logic [3:0] st, input logic en);
    exp_t e;
    e.st   = st;
    e.ctrl = ctrl_of(st, en);
    e.imm  = cur_imm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Fetch with a number of wait cycles, then decode.
  task automatic fetch(input logic [6:0] o, input logic [2:0] f3, input int waits,
                       input logic [1:0] imm);
    op      = o;
    funct3  = f3;
    cur_imm = imm;
    for (int i = 0; i < waits; i++) begin
      mem_ready = 1'b0;
      cyc(4'd0, 1'b0);
    end
    mem_ready = 1'b1;
    cyc(4'd0, 1'b1);
    mem_ready = 1'b0;
    cyc(4'd1, 1'b0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st) begin
        errors++;
        $display("FAIL state: got %0d expected %0d (t=%0t)", state, e.st, $time);
      end
      checks++;
      if (obs !== e.ctrl) begin
        errors++;
        $display("FAIL ctrl in state %0d: got %b expected %b (t=%0t)", e.st, obs, e.ctrl, $time);
      end
      checks++;
      if (ImmSrc !== e.imm) begin
        errors++;
        $display("FAIL ImmSrc in state %0d: got %b expected %b (t=%0t)", e.st, ImmSrc, e.imm,
                 $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; op = '0; funct3 = '0; Zero = 1'b0; ALUR31 = 1'b0; mem_ready = 1'b0;
    cur_imm = 2'b00;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // lw, no waits: 0,1,2,3,4
    fetch(7'b0000011, 3'b000, 0, 2'b00);
    cyc(4'd2, 1'b0);
    mem_ready = 1'b1; cyc(4'd3, 1'b0);
    mem_ready = 1'b0; cyc(4'd4, 1'b0);

    // lw with two fetch waits and one read wait
    fetch(7'b0000011, 3'b010, 2, 2'b00);
    mem_ready = 1'b1; cyc(4'd2, 1'b0);
    mem_ready = 1'b0; cyc(4'd3, 1'b0);
    mem_ready = 1'b1; cyc(4'd3, 1'b0);
    mem_ready = 1'b0; cyc(4'd4, 1'b0);

    // sw with three write waits: MemWrite held four cycles
    fetch(7'b0100011, 3'b010, 0, 2'b01);
    mem_ready = 1'b1; cyc(4'd2, 1'b0);
    mem_ready = 1'b0; cyc(4'd5, 1'b0); cyc(4'd5, 1'b0); cyc(4'd5, 1'b0);
    mem_ready = 1'b1; cyc(4'd5, 1'b0);

    // R-type and I-type; mem_ready toggling is ignored here
    fetch(7'b0110011, 3'b000, 0, 2'b00);
    mem_ready = 1'b1; cyc(4'd6, 1'b0); cyc(4'd8, 1'b0);
    fetch(7'b0010011, 3'b000, 0, 2'b00);
    cyc(4'd7, 1'b0); cyc(4'd8, 1'b0);

    // Branches: beq taken/not taken, bne, blt, bge, bgeu
    fetch(7'b1100011, 3'b000, 0, 2'b10); Zero = 1'b1; ALUR31 = 1'b0; cyc(4'd9, 1'b1);
    fetch(7'b1100011, 3'b000, 0, 2'b10); Zero = 1'b0; ALUR31 = 1'b1; cyc(4'd9, 1'b0);
    fetch(7'b1100011, 3'b001, 0, 2'b10); Zero = 1'b1; ALUR31 = 1'b0; cyc(4'd9, 1'b0);
    fetch(7'b1100011, 3'b100, 0, 2'b10); Zero = 1'b0; ALUR31 = 1'b1; cyc(4'd9, 1'b1);
    fetch(7'b1100011, 3'b101, 0, 2'b10); Zero = 1'b1; ALUR31 = 1'b0; cyc(4'd9, 1'b1);
    fetch(7'b1100011, 3'b111, 0, 2'b10); Zero = 1'b0; ALUR31 = 1'b1; cyc(4'd9, 1'b0);
    Zero = 1'b0; ALUR31 = 1'b0;

    // jal, jalr
    fetch(7'b1101111, 3'b000, 0, 2'b11);
    cyc(4'd10, 1'b0); cyc(4'd8, 1'b0);
    fetch(7'b1100111, 3'b000, 0, 2'b00);
    cyc(4'd11, 1'b0); cyc(4'd12, 1'b0); cyc(4'd8, 1'b0);

    // lui, auipc
    fetch(7'b0110111, 3'b000, 0, 2'b00); cyc(4'd13, 1'b0);
    fetch(7'b0010111, 3'b000, 0, 2'b00); cyc(4'd13, 1'b0);

    // Reset during a MEMREAD wait abandons the access
    fetch(7'b0000011, 3'b010, 0, 2'b00);
    cyc(4'd2, 1'b0);
    mem_ready = 1'b0; cyc(4'd3, 1'b0);
    reset = 1'b1; cyc(4'd3, 1'b0);
    reset = 1'b0; cyc(4'd0, 1'b0);

    // Reset during a MEMWRITE wait
    fetch(7'b0100011, 3'b010, 0, 2'b01);
    cyc(4'd2, 1'b0);
    reset = 1'b1; cyc(4'd5, 1'b0);
    reset = 1'b0; cyc(4'd0, 1'b0);

    // Branch with funct3 010 traps
    fetch(7'b1100011, 3'b010, 0, 2'b10);
    cyc(4'd14, 1'b0); cyc(4'd14, 1'b0);
    reset = 1'b1; cyc(4'd14, 1'b0);
    reset = 1'b0; cyc(4'd0, 1'b0);

    // Illegal opcode: trap is absorbing, mem_ready ignored
    fetch(7'b0000000, 3'b000, 0, 2'b00);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      cyc(4'd14, 1'b0);
    end
    reset = 1'b1; mem_ready = 1'b1; cyc(4'd14, 1'b0);
    reset = 1'b0; mem_ready = 1'b0; cyc(4'd0, 1'b0);

    // Drain the scoreboard with a bound
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
